cpu_ctrl_seq: RTL and testbench
===============================

Name: cpu_ctrl_seq

Overview:
- Instruction-cycle sequencer for the 8-bit accumulator CPU.
- Consumes the `fetch` phase signal from the clock generator and the opcode/zero flag from the datapath.
- Steps an 8-phase cycle per instruction and drives the strobes for PC, IR, accumulator, memory read/write and data bus enable.
- Sits directly downstream of the clock generator; clocked on the same phase clock the generator exports to the core.

Parameters:
- OPW, 3, opcode width (fixed encoding below).
- CNTW, 16, width of the optional retired-instruction counter.

Ports:
- clk  in  1  core phase clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- fetch  in  1  fetch phase from clock generator, sampled on clk rising edge
- opcode  in  OPW  current IR opcode (HLT=000 SKZ=001 ADD=010 ANDD=011 XORR=100 LDA=101 STO=110 JMP=111)
- zero  in  1  accumulator-zero flag
- inc_pc  out  1  increment PC
- load_pc  out  1  load PC from IR address
- load_ir  out  1  load IR byte
- load_acc  out  1  load accumulator from ALU
- rd  out  1  memory read
- wr  out  1  memory write
- datactl_ena  out  1  drive accumulator onto data bus
- halt  out  1  CPU halted (sticky)
- instr_cnt  out  CNTW  retired instructions (see Optional Feature)

Behaviour:
- Reset is synchronous, active-high. On a clk edge with reset=1:
  - all outputs 0, ena=0, state=S0, halted=0, instr_cnt=0.
  - Reset mid-instruction aborts the instruction immediately.
- Enable:
  - While ena=0: state held at S0, all strobes 0.
  - The first clk edge with fetch=1 and reset=0 sets ena=1 and executes S0 on that same edge.
  - ena then stays 1 until reset.
- Timing: outputs are registered. On the edge that executes Sk, the output registers load the Sk values below and the state advances to S(k+1 mod 8). The strobes for Sk are therefore visible for exactly the one cycle after that edge.
- "ALU" means opcode ∈ {ADD, ANDD, XORR, LDA}.
- Strobes asserted per state (all unlisted strobes are 0):
  - S0: rd, load_ir
  - S1: rd, load_ir, inc_pc
  - S2: none
  - S3: inc_pc. If opcode=HLT: set halted and go to HALT instead of S4.
  - S4:
    - ALU: rd
    - JMP: load_pc
    - STO: datactl_ena
  - S5:
    - ALU: rd, load_acc
    - SKZ and zero=1: inc_pc
    - JMP: load_pc, inc_pc
    - STO: wr, datactl_ena
  - S6:
    - ALU: rd
    - STO: datactl_ena
  - S7: SKZ and zero=1: inc_pc. Instruction retires; next state is S0.
- HALT:
  - halt=1, all other strobes 0.
  - Remains in HALT regardless of fetch, opcode or zero; only reset exits.
  - HLT is counted as retired on entry to HALT.
- opcode and zero are sampled on each edge; both are only meaningful from S3 onward.
- fetch is ignored once ena=1. Phase alignment is guaranteed by construction: 8 states per 8 clk, matching the fetch period.
- Mutual exclusion invariants:
  - never rd and wr in the same cycle.
  - wr only when datactl_ena=1.
  - load_ir only in S0/S1.
- Illegal or unknown state encoding recovers to S0 on the next edge with all strobes 0.

Optional Feature:
- Macro CTRL_INSTR_CNT_EN.
- Defined: instr_cnt increments by 1 on each S7 retirement and on entry to HALT. It saturates at all-ones (no wrap) and clears on reset.
- Undefined: instr_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Reset, fetch held 0 for 10 clk -> all strobes 0, state stays S0; first edge with fetch=1 -> rd=1, load_ir=1 in the following cycle.
- LDA (101) cycle -> rd high in S0,S1,S4,S5,S6; load_acc only in S5; inc_pc in S1,S3; wr never high.
- STO (110) -> datactl_ena in S4..S6, wr only in S5, rd 0 in S4..S7.
- SKZ (001) with zero=1 -> inc_pc in S1,S3,S5,S7 (4 pulses); with zero=0 -> inc_pc in S1,S3 only.
- JMP (111) -> load_pc in S4,S5; inc_pc in S5. HLT (000) -> halt=1 from the cycle after S3 and held for 50 clk with other strobes 0. Reset then clears halt, and the sequencer restarts on the next fetch.
- With CTRL_INSTR_CNT_EN, run 3 ADD then HLT -> instr_cnt=4; reset asserted mid-S4 -> next cycle all strobes 0, instr_cnt=0.

Source files
------------

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: 8-phase instruction-cycle sequencer for the 8-bit accumulator CPU.
// Produces registered PC/IR/ACC/memory/bus strobes from the phase state, opcode and zero flag.
// Optional build macro: CTRL_INSTR_CNT_EN enables the saturating retired-instruction counter.
//
// state  | meaning
// S0     | fetch high byte: rd, load_ir
// S1     | fetch low byte: rd, load_ir, inc_pc
// S2     | idle
// S3     | inc_pc; HLT diverts to S_HALT
// S4     | operand phase 1 (ALU rd, JMP load_pc, STO bus drive)
// S5     | operand phase 2 (ALU load_acc, SKZ skip, JMP load, STO write)
// S6     | operand phase 3 (ALU rd, STO bus drive)
// S7     | SKZ second skip pulse, retire, back to S0
// S_HALT | halted; only reset leaves
module cpu_ctrl_seq #(
  parameter int OPW  = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  output logic            inc_pc,
  output logic            load_pc,
  output logic            load_ir,
  output logic            load_acc,
  output logic            rd,
  output logic            wr,
  output logic            datactl_ena,
  output logic            halt,
  output logic [CNTW-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S0     = 4'd0,
    S1     = 4'd1,
    S2     = 4'd2,
    S3     = 4'd3,
    S4     = 4'd4,
    S5     = 4'd5,
    S6     = 4'd6,
    S7     = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [OPW-1:0] OP_HLT  = OPW'(0);
  localparam logic [OPW-1:0] OP_SKZ  = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
  localparam logic [OPW-1:0] OP_ANDD = OPW'(3);
  localparam logic [OPW-1:0] OP_XORR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA  = OPW'(5);
  localparam logic [OPW-1:0] OP_STO  = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(7);

  state_t r_state;
  logic   r_ena;
  logic   r_inc_pc, r_load_pc, r_load_ir, r_load_acc;
  logic   r_rd, r_wr, r_datactl_ena, r_halt;

  logic w_alu, w_sto, w_jmp, w_skz_taken, w_hlt;

  assign w_alu       = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                       (opcode == OP_XORR) || (opcode == OP_LDA);
  assign w_sto       = (opcode == OP_STO);
  assign w_jmp       = (opcode == OP_JMP);
  assign w_skz_taken = (opcode == OP_SKZ) && zero;
  assign w_hlt       = (opcode == OP_HLT);

  // Phase FSM: loads the strobes of the state being executed and advances the phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S0;
      r_ena         <= 1'b0;
      r_inc_pc      <= 1'b0;
      r_load_pc     <= 1'b0;
      r_load_ir     <= 1'b0;
      r_load_acc    <= 1'b0;
      r_rd          <= 1'b0;
      r_wr          <= 1'b0;
      r_datactl_ena <= 1'b0;
      r_halt        <= 1'b0;
    end else begin
      // every strobe is a single-cycle pulse unless the executed state re-asserts it
      r_inc_pc      <= 1'b0;
      r_load_pc     <= 1'b0;
      r_load_ir     <= 1'b0;
      r_load_acc    <= 1'b0;
      r_rd          <= 1'b0;
      r_wr          <= 1'b0;
      r_datactl_ena <= 1'b0;
      r_halt        <= 1'b0;
      if (!r_ena && !fetch) begin
        r_state <= S0;
      end else begin
        // first fetch enables and executes S0 on the same edge
        r_ena <= 1'b1;
        case (r_state)
          S0: begin
            r_rd      <= 1'b1;
            r_load_ir <= 1'b1;
            r_state   <= S1;
          end
          S1: begin
            r_rd      <= 1'b1;
            r_load_ir <= 1'b1;
            r_inc_pc  <= 1'b1;
            r_state   <= S2;
          end
          S2: r_state <= S3;
          S3: begin
            r_inc_pc <= 1'b1;
            if (w_hlt) begin
              r_halt  <= 1'b1;
              r_state <= S_HALT;
            end else begin
              r_state <= S4;
            end
          end
          S4: begin
            r_rd          <= w_alu;
            r_load_pc     <= w_jmp;
            r_datactl_ena <= w_sto;
            r_state       <= S5;
          end
          S5: begin
            r_rd          <= w_alu;
            r_load_acc    <= w_alu;
            r_inc_pc      <= w_skz_taken || w_jmp;
            r_load_pc     <= w_jmp;
            r_wr          <= w_sto;
            r_datactl_ena <= w_sto;
            r_state       <= S6;
          end
          S6: begin
            r_rd          <= w_alu;
            r_datactl_ena <= w_sto;
            r_state       <= S7;
          end
          S7: begin
            r_inc_pc <= w_skz_taken;
            r_state  <= S0;
          end
          S_HALT: begin
            r_halt  <= 1'b1;
            r_state <= S_HALT;
          end
          default: r_state <= S0;
        endcase
      end
    end
  end

  assign inc_pc      = r_inc_pc;
  assign load_pc     = r_load_pc;
  assign load_ir     = r_load_ir;
  assign load_acc    = r_load_acc;
  assign rd          = r_rd;
  assign wr          = r_wr;
  assign datactl_ena = r_datactl_ena;
  assign halt        = r_halt;

`ifdef CTRL_INSTR_CNT_EN
  logic [CNTW-1:0] r_instr_cnt;
  logic            w_retire;

  // an instruction retires when S7 executes or when HLT diverts into S_HALT
  assign w_retire = r_ena && ((r_state == S7) || ((r_state == S3) && w_hlt));

  // Saturating retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_cnt <= '0;
    end else if (w_retire && (r_instr_cnt != {CNTW{1'b1}})) begin
      r_instr_cnt <= r_instr_cnt + 1'b1;
    end
  end

  assign instr_cnt = r_instr_cnt;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: randomized directed bench for cpu_ctrl_seq against a phase-level reference model.
module tb_cpu_ctrl_seq;

  localparam int OPW  = 3;
  localparam int CNTW = 16;
`ifdef CTRL_INSTR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDD = 3'd3;
  localparam logic [2:0] XORR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  logic            clk = 1'b0;
  logic            reset, fetch, zero;
  logic [OPW-1:0]  opcode;
  logic            inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt;
  logic [CNTW-1:0] instr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: enabled, phase number 0..7, halted, retired count
  bit          m_ena    = 1'b0;
  bit          m_halted = 1'b0;
  int          m_phase  = 0;
  int unsigned m_cnt    = 0;

  always #5 clk = ~clk;

  cpu_ctrl_seq #(.OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .fetch(fetch), .opcode(opcode), .zero(zero),
    .inc_pc(inc_pc), .load_pc(load_pc), .load_ir(load_ir), .load_acc(load_acc),
    .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt), .instr_cnt(instr_cnt)
  );

  // strobe vector {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt} per signal rule
  function automatic logic [7:0] strobes(input int ph, input logic [2:0] op, input logic z);
    bit alu, sto, jmp, skz;
    bit s_inc, s_lpc, s_lir, s_lacc, s_rd, s_wr, s_den;
    alu    = (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
    sto    = (op == STO);
    jmp    = (op == JMP);
    skz    = (op == SKZ);
    s_inc  = (ph == 1) || (ph == 3) || (ph == 5 && (jmp || (skz && z))) || (ph == 7 && skz && z);
    s_lpc  = jmp && (ph == 4 || ph == 5);
    s_lir  = (ph <= 1);
    s_lacc = alu && (ph == 5);
    s_rd   = (ph <= 1) || (alu && ph >= 4 && ph <= 6);
    s_wr   = sto && (ph == 5);
    s_den  = sto && ph >= 4 && ph <= 6;
    return {s_inc, s_lpc, s_lir, s_lacc, s_rd, s_wr, s_den, 1'b0};
  endfunction

  task automatic cyc(input logic rst, input logic f, input logic [2:0] op, input logic z);
    logic [7:0]      exp_s;
    logic [7:0]      obs;
    logic [CNTW-1:0] exp_cnt;
    int              ph;
    ph     = m_phase;
    reset  = rst;
    fetch  = f;
    opcode = op;
    zero   = z;
    if (rst) begin
      exp_s = 8'h00; m_ena = 1'b0; m_phase = 0; m_halted = 1'b0; m_cnt = 0;
    end else if (m_halted) begin
      exp_s = 8'h01;
    end else if (!m_ena && !f) begin
      exp_s = 8'h00;
    end else begin
      m_ena = 1'b1;
      exp_s = strobes(m_phase, op, z);
      if (m_phase == 3 && op == HLT) begin
        m_halted = 1'b1;
        exp_s[0] = 1'b1;
        if (m_cnt < 32'hFFFF) m_cnt++;
      end else begin
        if (m_phase == 7 && m_cnt < 32'hFFFF) m_cnt++;
        m_phase = (m_phase + 1) % 8;
      end
    end
    exp_cnt = CNT_EN ? CNTW'(m_cnt) : '0;
    @(posedge clk);
    #1;
    obs = {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt};
    n_tests++;
    assert (obs === exp_s) else begin
      n_fail++;
      $error("FAIL strobes ph=%0d op=%0d rst=%0b observed=%b expected=%b", ph, op, rst, obs, exp_s);
    end
    n_tests++;
    assert (instr_cnt === exp_cnt) else begin
      n_fail++;
      $error("FAIL instr_cnt observed=%0d expected=%0d", instr_cnt, exp_cnt);
    end
    n_tests++;
    assert (!(rd && wr) && !(wr && !datactl_ena)) else begin
      n_fail++;
      $error("FAIL exclusion rd=%0b wr=%0b datactl_ena=%0b expected rd&wr=0 and wr->datactl_ena", rd, wr, datactl_ena);
    end
  endtask

  // one full instruction from phase 0; opcode is random before S3; zmode 0/1 fixed, 2 random
  task automatic run_instr(input logic [2:0] op, input int zmode);
    logic [2:0] o;
    logic       z;
    logic       f;
    for (int k = 0; k < 8; k++) begin
      if (m_halted) break;
      o = (k < 3) ? 3'($urandom) : op;
      z = (zmode == 2) ? 1'($urandom) : (zmode == 1);
      f = (k == 0) ? 1'b1 : 1'($urandom);
      cyc(1'b0, f, o, z);
    end
  endtask

  function automatic logic [2:0] rand_op_no_hlt();
    logic [2:0] o;
    o = 3'($urandom);
    if (o == HLT) o = SKZ;
    return o;
  endfunction

  initial begin
    reset = 1'b1; fetch = 1'b0; opcode = '0; zero = 1'b0;
    cyc(1'b1, 1'b1, 3'($urandom), 1'b0);
    cyc(1'b1, 1'b0, 3'($urandom), 1'b1);
    // idle: not enabled, strobes stay low
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 3'($urandom), 1'($urandom));
    // directed opcodes
    run_instr(LDA, 2);
    run_instr(STO, 2);
    run_instr(SKZ, 1);
    run_instr(SKZ, 0);
    run_instr(JMP, 2);
    // randomized non-halting instruction stream
    for (int i = 0; i < 40; i++) run_instr(rand_op_no_hlt(), 2);
    // reset on the edge that would execute S4
    for (int k = 0; k < 4; k++) cyc(1'b0, (k == 0), ADD, 1'($urandom));
    cyc(1'b1, 1'b0, ADD, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 3'($urandom), 1'($urandom));
    // three ADDs then HLT, then hold in halt
    for (int i = 0; i < 3; i++) run_instr(ADD, 2);
    run_instr(HLT, 2);
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'($urandom), 3'($urandom), 1'($urandom));
    // reset clears halt; restart on next fetch
    cyc(1'b1, 1'b0, 3'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 3'($urandom), 1'($urandom));
    for (int i = 0; i < 25; i++) run_instr(3'($urandom), 2);
    run_instr(HLT, 2);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'($urandom), 3'($urandom), 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
